// File: rtl/fraction_reducer.sv
// fraction_reducer: reduces num/den to lowest terms using an external GCD block and two restoring dividers
module fraction_reducer #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] num_out,
  output logic [WIDTH-1:0] den_out,
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_a,
  output logic [WIDTH-1:0] gcd_b,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result
);
  localparam int CW = $clog2((TIMEOUT > WIDTH ? TIMEOUT : WIDTH) + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] DV_LAST = CW'(WIDTH - 1);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DIV, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, g_q, g_d;
  logic [WIDTH-1:0] nq_q, nq_d, nr_q, nr_d, dq_q, dq_d, dr_q, dr_d;
  logic [WIDTH-1:0] no_q, no_d, dn_q, dn_d;
  logic err_q, err_d;
  logic [2*WIDTH-1:0] n_step, d_step;

  // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r, q, d);
    logic [WIDTH:0] t;
    t = {r, q[WIDTH-1]};
    return (t >= {1'b0, d}) ? {WIDTH'(t - {1'b0, d}), q[WIDTH-2:0], 1'b1}
                            : {t[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
  endfunction

  assign n_step = div_step(nr_q, nq_q, g_q);
  assign d_step = div_step(dr_q, dq_q, g_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    g_d     = g_q;
    nq_d    = nq_q;
    nr_d    = nr_q;
    dq_d    = dq_q;
    dr_d    = dr_q;
    no_d    = no_q;
    dn_d    = dn_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (start) begin
        a_d     = num;
        b_d     = den;
        state_d = ~|{num, den} ? DONE : REQ;
        if (~|{num, den}) begin
          err_d = 1'b1;
          no_d  = '0;
          dn_d  = '0;
        end
      end
      REQ: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: if (gcd_done) begin
        g_d     = gcd_result;
        nq_d    = a_q;
        nr_d    = '0;
        dq_d    = b_q;
        dr_d    = '0;
        cnt_d   = '0;
        state_d = DIV;
      end else if (cnt_q == TO_LAST) begin
        state_d = DONE;
        err_d   = 1'b1;
        no_d    = '0;
        dn_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      DIV: begin
        {nr_d, nq_d} = n_step;
        {dr_d, dq_d} = d_step;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == DV_LAST) begin
          state_d = DONE;
          no_d    = n_step[WIDTH-1:0];
          dn_d    = d_step[WIDTH-1:0];
          err_d   = 1'b0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      g_q     <= '0;
      nq_q    <= '0;
      nr_q    <= '0;
      dq_q    <= '0;
      dr_q    <= '0;
      no_q    <= '0;
      dn_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      g_q     <= g_d;
      nq_q    <= nq_d;
      nr_q    <= nr_d;
      dq_q    <= dq_d;
      dr_q    <= dr_d;
      no_q    <= no_d;
      dn_q    <= dn_d;
      err_q   <= err_d;
    end
  end

  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign gcd_start = state_q == REQ;
  assign err       = err_q;
  assign num_out   = no_q;
  assign den_out   = dn_q;
  assign gcd_a     = a_q;
  assign gcd_b     = b_q;
endmodule

// File: tb/tb_fraction_reducer.sv
// tb_fraction_reducer: directed scoreboard bench with a behavioural GCD responder
module tb_fraction_reducer;
  localparam int W  = 8;
  localparam int TO = 255;
  logic clk = 1'b0;
  logic rst, start, gcd_done, busy, done, err, gcd_start;
  logic [W-1:0] num, den, gcd_result, num_out, den_out, gcd_a, gcd_b;
  int tests = 0;
  int fails = 0;
  typedef struct packed {
    logic [W-1:0] n;
    logic [W-1:0] d;
    logic         e;
  } exp_t;
  exp_t sb[$];

  fraction_reducer #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .num(num), .den(den),
    .busy(busy), .done(done), .err(err), .num_out(num_out), .den_out(den_out),
    .gcd_start(gcd_start), .gcd_a(gcd_a), .gcd_b(gcd_b),
    .gcd_done(gcd_done), .gcd_result(gcd_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int gcdf(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // dly < 0: GCD never answers. poke > 0: a stray 9/6 start is pulsed in that cycle.
  task automatic req(input logic [W-1:0] n, input logic [W-1:0] d, input int dly, input int poke);
    int g, kreq, kgd, kexp;
    bit zero, seen;
    exp_t e, o;
    @(negedge clk);
    chk("idle_before", {30'd0, busy, done}, 0);
    zero = (n == 0) && (d == 0);
    g = zero ? 1 : gcdf(int'(n), int'(d));
    if (zero || dly < 0) e = {{W{1'b0}}, {W{1'b0}}, 1'b1};
    else e = {W'(int'(n) / g), W'(int'(d) / g), 1'b0};
    sb.push_back(e);
    num = n;
    den = d;
    start = 1'b1;
    kreq = -1;
    kgd = -1;
    seen = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      gcd_done = 1'b0;
      start = (k == poke);
      if (k == poke) begin
        num = 8'd9;
        den = 8'd6;
      end
      if (gcd_start) begin
        kreq = k;
        chk("req_latency", k, 1);
        chk("gcd_a", {24'd0, gcd_a}, {24'd0, n});
        chk("gcd_b", {24'd0, gcd_b}, {24'd0, d});
      end
      if (dly >= 0 && kreq > 0 && kgd < 0 && k == kreq + dly) begin
        chk("gcd_a_hold", {24'd0, gcd_a}, {24'd0, n});
        chk("gcd_b_hold", {24'd0, gcd_b}, {24'd0, d});
        gcd_done = 1'b1;
        gcd_result = W'(g);
        kgd = k;
      end
      if (done) begin
        kexp = zero ? 1 : (dly < 0) ? TO + 2 : kgd + W + 1;
        chk("done_latency", k, kexp);
        chk("gcd_start_seen", {31'd0, kreq > 0}, {31'd0, !zero});
        if (sb.size() == 0) chk("sb_empty", 1, 0);
        else begin
          o = sb.pop_front();
          chk("num_out", {24'd0, num_out}, {24'd0, o.n});
          chk("den_out", {24'd0, den_out}, {24'd0, o.d});
          chk("err", {31'd0, err}, {31'd0, o.e});
        end
        seen = 1'b1;
        break;
      end
    end
    gcd_done = 1'b0;
    start = 1'b0;
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    num = '0;
    den = '0;
    gcd_done = 1'b0;
    gcd_result = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", {28'd0, busy, done, err, gcd_start}, 0);
    chk("reset_out", {16'd0, num_out, den_out}, 0);
    chk("reset_gcd", {16'd0, gcd_a, gcd_b}, 0);
    rst = 1'b0;
    req(8'd20, 8'd15, 3, 0);
    req(8'd56, 8'd49, 3, 0);
    req(8'd0, 8'd16, 3, 0);
    req(8'd20, 8'd0, 3, 0);
    req(8'd0, 8'd0, 3, 0);
    req(8'd30, 8'd12, -1, 0);
    @(negedge clk);
    gcd_done = 1'b1;
    gcd_result = 8'd5;
    @(negedge clk);
    gcd_done = 1'b0;
    chk("late_gcd_done", {13'd0, busy, done, err, num_out, den_out}, {13'd0, 1'b0, 1'b0, 1'b1, 16'd0});
    req(8'd21, 8'd14, TO, 0);
    req(8'd45, 8'd30, 2, 6);
    @(negedge clk);
    num = 8'd30;
    den = 8'd12;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ctl", {28'd0, busy, done, err, gcd_start}, 0);
    chk("midrst_out", {16'd0, num_out, den_out}, 0);
    chk("midrst_gcd", {16'd0, gcd_a, gcd_b}, 0);
    gcd_done = 1'b1;
    gcd_result = 8'd6;
    @(negedge clk);
    gcd_done = 1'b0;
    chk("post_rst_gcd_done", {13'd0, busy, done, err, num_out, den_out}, 0);
    req(8'd255, 8'd255, 1, 0);
    @(negedge clk);
    chk("final_idle", {30'd0, busy, done}, 0);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
